// File: rtl/axi_rw_sim_mem.sv
// AXI4 subordinate memory model with split read and write ports sharing one
// byte-addressed memory; each port serves one outstanding burst at a time.

package axi_rw_sim_mem_pkg;

   typedef struct packed {
      logic [11:0] id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
      logic [5:0]  atop;
      logic [0:0]  user;
   } aw_chan_t;

   typedef struct packed {
      logic [11:0] id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
      logic [0:0]  user;
   } ar_chan_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
      logic [0:0]  user;
   } w_chan_t;

   typedef struct packed {
      logic [11:0] id;
      logic [1:0]  resp;
      logic [0:0]  user;
   } b_chan_t;

   typedef struct packed {
      logic [11:0] id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [0:0]  user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } axi_rsp_t;

endpackage

module axi_rw_sim_mem #(
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned AddrWidth    = 32,
   parameter int unsigned UserWidth    = 1,
   parameter int unsigned AxiIdWidth   = 12,
   parameter int unsigned MemAddrWidth = 12,
   parameter type axi_req_t = axi_rw_sim_mem_pkg::axi_req_t,
   parameter type axi_rsp_t = axi_rw_sim_mem_pkg::axi_rsp_t
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  axi_req_t axi_read_req_i,
   output axi_rsp_t axi_read_rsp_o,
   input  axi_req_t axi_write_req_i,
   output axi_rsp_t axi_write_rsp_o
);

   localparam int unsigned NumLanes = DataWidth / 8;
   localparam int unsigned OffW     = $clog2(NumLanes);
   localparam int unsigned WordW    = MemAddrWidth - OffW;
   localparam int unsigned Depth    = 2 ** WordW;

   typedef enum logic [0:0] {R_IDLE, R_BURST} r_state_e;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

   logic [DataWidth-1:0] mem [Depth];

   r_state_e              r_state_reg;
   logic [AxiIdWidth-1:0] r_id_reg;
   logic [AddrWidth-1:0]  r_addr_reg;
   logic [7:0]            r_len_reg;
   logic [2:0]            r_size_reg;
   logic [1:0]            r_burst_reg;
   logic [7:0]            r_cnt_reg;

   w_state_e              w_state_reg;
   logic [AxiIdWidth-1:0] w_id_reg;
   logic [AddrWidth-1:0]  w_addr_reg;
   logic [7:0]            w_len_reg;
   logic [2:0]            w_size_reg;
   logic [1:0]            w_burst_reg;
   logic [7:0]            w_cnt_reg;
   logic                  w_err_reg;

   logic                 w_hs;
   logic [WordW-1:0]     r_word;
   logic [WordW-1:0]     w_word;
   logic [UserWidth-1:0] zero_user;
   logic                 unused;

   assign zero_user = '0;
   assign unused    = ^{axi_read_req_i, axi_write_req_i};
   assign r_word    = r_addr_reg[MemAddrWidth-1:OffW];
   assign w_word    = w_addr_reg[MemAddrWidth-1:OffW];
   assign w_hs      = (w_state_reg == W_DATA) && axi_write_req_i.w_valid;

   // WRAP keeps the address inside the aligned (len+1)*2^size window.
   function automatic logic [AddrWidth-1:0] next_addr(
      input logic [AddrWidth-1:0] addr,
      input logic [7:0]           len,
      input logic [2:0]           size,
      input logic [1:0]           burst
   );
      logic [AddrWidth-1:0] incr;
      logic [AddrWidth-1:0] mask;
      incr = AddrWidth'(1) << size;
      mask = ((AddrWidth'(len) + AddrWidth'(1)) << size) - AddrWidth'(1);
      case (burst)
         2'b00:   next_addr = addr;
         2'b10:   next_addr = (addr & ~mask) | ((addr + incr) & mask);
         default: next_addr = addr + incr;
      endcase
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state_reg <= R_IDLE;
         r_id_reg    <= '0;
         r_addr_reg  <= '0;
         r_len_reg   <= '0;
         r_size_reg  <= '0;
         r_burst_reg <= '0;
         r_cnt_reg   <= '0;
      end else begin
         case (r_state_reg)
            R_IDLE: begin
               if (axi_read_req_i.ar_valid) begin
                  r_id_reg    <= axi_read_req_i.ar.id;
                  r_addr_reg  <= axi_read_req_i.ar.addr;
                  r_len_reg   <= axi_read_req_i.ar.len;
                  r_size_reg  <= axi_read_req_i.ar.size;
                  r_burst_reg <= axi_read_req_i.ar.burst;
                  r_cnt_reg   <= '0;
                  r_state_reg <= R_BURST;
               end
            end
            R_BURST: begin
               if (axi_read_req_i.r_ready) begin
                  r_cnt_reg  <= r_cnt_reg + 8'd1;
                  r_addr_reg <= next_addr(r_addr_reg, r_len_reg, r_size_reg, r_burst_reg);
                  if (r_cnt_reg == r_len_reg) r_state_reg <= R_IDLE;
               end
            end
            default: r_state_reg <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         w_state_reg <= W_IDLE;
         w_id_reg    <= '0;
         w_addr_reg  <= '0;
         w_len_reg   <= '0;
         w_size_reg  <= '0;
         w_burst_reg <= '0;
         w_cnt_reg   <= '0;
         w_err_reg   <= 1'b0;
      end else begin
         case (w_state_reg)
            W_IDLE: begin
               if (axi_write_req_i.aw_valid) begin
                  w_id_reg    <= axi_write_req_i.aw.id;
                  w_addr_reg  <= axi_write_req_i.aw.addr;
                  w_len_reg   <= axi_write_req_i.aw.len;
                  w_size_reg  <= axi_write_req_i.aw.size;
                  w_burst_reg <= axi_write_req_i.aw.burst;
                  w_cnt_reg   <= '0;
                  w_err_reg   <= 1'b0;
                  w_state_reg <= W_DATA;
               end
            end
            W_DATA: begin
               if (axi_write_req_i.w_valid) begin
                  // The beat count, not w_last, decides where the burst ends.
                  if (axi_write_req_i.w.last != (w_cnt_reg == w_len_reg)) w_err_reg <= 1'b1;
                  w_cnt_reg  <= w_cnt_reg + 8'd1;
                  w_addr_reg <= next_addr(w_addr_reg, w_len_reg, w_size_reg, w_burst_reg);
                  if (w_cnt_reg == w_len_reg) w_state_reg <= W_RESP;
               end
            end
            W_RESP: begin
               if (axi_write_req_i.b_ready) w_state_reg <= W_IDLE;
            end
            default: w_state_reg <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_hs) begin
         for (int i = 0; i < NumLanes; i++) begin
            if (axi_write_req_i.w.strb[i]) mem[w_word][i*8 +: 8] <= axi_write_req_i.w.data[i*8 +: 8];
         end
      end
   end

   always_comb begin
      axi_read_rsp_o          = '0;
      axi_read_rsp_o.ar_ready = rst_ni && (r_state_reg == R_IDLE);
      axi_read_rsp_o.r_valid  = rst_ni && (r_state_reg == R_BURST);
      axi_read_rsp_o.r.id     = r_id_reg;
      axi_read_rsp_o.r.data   = mem[r_word];
      axi_read_rsp_o.r.resp   = 2'b00;
      axi_read_rsp_o.r.last   = (r_cnt_reg == r_len_reg);
      axi_read_rsp_o.r.user   = zero_user;
   end

   always_comb begin
      axi_write_rsp_o          = '0;
      axi_write_rsp_o.aw_ready = rst_ni && (w_state_reg == W_IDLE);
      axi_write_rsp_o.w_ready  = rst_ni && (w_state_reg == W_DATA);
      axi_write_rsp_o.b_valid  = rst_ni && (w_state_reg == W_RESP);
      axi_write_rsp_o.b.id     = w_id_reg;
      axi_write_rsp_o.b.resp   = w_err_reg ? 2'b10 : 2'b00;
      axi_write_rsp_o.b.user   = zero_user;
   end

endmodule

// File: tb/tb_axi_rw_sim_mem.sv
// Directed bench for axi_rw_sim_mem: single/partial writes, INCR/WRAP/FIXED
// bursts, w_last error, concurrent ports and mid-burst reset.

module tb_axi_rw_sim_mem;
   import axi_rw_sim_mem_pkg::*;

   logic     clk;
   logic     rst_n;
   axi_req_t rreq;
   axi_req_t wreq;
   axi_rsp_t rrsp;
   axi_rsp_t wrsp;
   int       checks;
   int       errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   axi_rw_sim_mem #(
      .DataWidth(32), .AddrWidth(32), .UserWidth(1), .AxiIdWidth(12), .MemAddrWidth(12),
      .axi_req_t(axi_req_t), .axi_rsp_t(axi_rsp_t)
   ) dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .axi_read_req_i(rreq),
      .axi_read_rsp_o(rrsp),
      .axi_write_req_i(wreq),
      .axi_write_rsp_o(wrsp)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [11:0] id);
      int n = 0;
      rreq.ar       = '0;
      rreq.ar.addr  = addr;
      rreq.ar.len   = len;
      rreq.ar.size  = 3'd2;
      rreq.ar.burst = burst;
      rreq.ar.id    = id;
      rreq.ar_valid = 1'b1;
      while (rrsp.ar_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("ar_handshake", 64'(n < 50), 1);
      @(negedge clk);
      rreq.ar_valid = 1'b0;
   endtask

   task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [11:0] id);
      int n = 0;
      wreq.aw       = '0;
      wreq.aw.addr  = addr;
      wreq.aw.len   = len;
      wreq.aw.size  = 3'd2;
      wreq.aw.burst = burst;
      wreq.aw.id    = id;
      wreq.aw_valid = 1'b1;
      while (wrsp.aw_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("aw_handshake", 64'(n < 50), 1);
      @(negedge clk);
      wreq.aw_valid = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
      int n = 0;
      wreq.w        = '0;
      wreq.w.data   = data;
      wreq.w.strb   = strb;
      wreq.w.last   = last;
      wreq.w_valid  = 1'b1;
      while (wrsp.w_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("w_handshake", 64'(n < 50), 1);
      @(negedge clk);
      wreq.w_valid = 1'b0;
   endtask

   task automatic b_expect(input logic [11:0] id, input logic [1:0] resp);
      int n = 0;
      wreq.b_ready = 1'b0;
      while (wrsp.b_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("b_valid", 64'(n < 50), 1);
      chk("b_id", wrsp.b.id, id);
      chk("b_resp", wrsp.b.resp, resp);
      $display("write burst done: id=%0h resp=%0d", wrsp.b.id, wrsp.b.resp);
      wreq.b_ready = 1'b1;
      @(negedge clk);
      wreq.b_ready = 1'b0;
   endtask

   task automatic r_expect(input string tag, input logic [31:0] d, input logic last,
                           input logic [11:0] id, input int hold);
      int n = 0;
      rreq.r_ready = 1'b0;
      while (rrsp.r_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk({tag, "_valid"}, 64'(n < 50), 1);
      chk({tag, "_data"}, rrsp.r.data, d);
      chk({tag, "_last"}, rrsp.r.last, last);
      chk({tag, "_id"}, rrsp.r.id, id);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, rrsp.r_valid, 1);
         chk({tag, "_hold_data"}, rrsp.r.data, d);
      end
      rreq.r_ready = 1'b1;
      @(negedge clk);
      rreq.r_ready = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [11:0] id,
                           input logic [31:0] exp[$], input int hold);
      ar_send(addr, len, burst, id);
      for (int i = 0; i <= int'(len); i++)
         r_expect($sformatf("%s_b%0d", tag, i), exp[i], i == int'(len), id, hold);
      $display("read burst %s done: addr=%0h len=%0d burst=%0d", tag, addr, len, burst);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      rreq   = '0;
      wreq   = '0;
      rst_n  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ar_ready", rrsp.ar_ready, 0);
      chk("rst_aw_ready", wrsp.aw_ready, 0);
      chk("rst_r_valid", rrsp.r_valid, 0);
      chk("rst_w_ready", wrsp.w_ready, 0);
      chk("rst_b_valid", wrsp.b_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ar_ready", rrsp.ar_ready, 1);
      chk("idle_aw_ready", wrsp.aw_ready, 1);
      chk("rd_port_aw_ready_tied", rrsp.aw_ready, 0);
      chk("wr_port_ar_ready_tied", wrsp.ar_ready, 0);

      // Single word write and readback
      aw_send(32'h10, 8'd0, 2'b01, 12'h5);
      w_send(32'hDEADBEEF, 4'hF, 1'b1);
      chk("single_beat_only", wrsp.w_ready, 0);
      b_expect(12'h5, 2'b00);
      rd_check("single", 32'h10, 8'd0, 2'b01, 12'h7, {32'hDEADBEEF}, 0);

      // Partial strobe merge
      aw_send(32'h20, 8'd0, 2'b01, 12'h1);
      w_send(32'h11223344, 4'hF, 1'b1);
      b_expect(12'h1, 2'b00);
      aw_send(32'h20, 8'd0, 2'b01, 12'h2);
      w_send(32'hAABBCCDD, 4'b0101, 1'b1);
      b_expect(12'h2, 2'b00);
      rd_check("strobe", 32'h20, 8'd0, 2'b01, 12'h3, {32'h11BB33DD}, 0);

      // INCR burst, then again with r_ready held low between beats
      aw_send(32'h40, 8'd3, 2'b01, 12'h3);
      w_send(32'd1, 4'hF, 1'b0);
      w_send(32'd2, 4'hF, 1'b0);
      w_send(32'd3, 4'hF, 1'b0);
      w_send(32'd4, 4'hF, 1'b1);
      b_expect(12'h3, 2'b00);
      rd_check("incr", 32'h40, 8'd3, 2'b01, 12'h4, {32'd1, 32'd2, 32'd3, 32'd4}, 0);
      rd_check("incr_hold", 32'h40, 8'd3, 2'b01, 12'h4, {32'd1, 32'd2, 32'd3, 32'd4}, 2);

      // WRAP from 0x48 visits 0x48, 0x4C, 0x40, 0x44; FIXED repeats one word
      rd_check("wrap", 32'h48, 8'd3, 2'b10, 12'h6, {32'd3, 32'd4, 32'd1, 32'd2}, 0);
      rd_check("fixed", 32'h40, 8'd2, 2'b00, 12'h8, {32'd1, 32'd1, 32'd1}, 0);

      // Early w_last: both beats still taken, response is SLVERR
      aw_send(32'h60, 8'd1, 2'b01, 12'h9);
      w_send(32'h55, 4'hF, 1'b1);
      chk("early_last_still_ready", wrsp.w_ready, 1);
      w_send(32'h66, 4'hF, 1'b1);
      b_expect(12'h9, 2'b10);
      rd_check("early_last", 32'h60, 8'd1, 2'b01, 12'h9, {32'h55, 32'h66}, 0);

      // Both ports busy at the same time on disjoint addresses
      fork
         begin
            aw_send(32'h80, 8'd1, 2'b01, 12'hA);
            w_send(32'hCAFE0001, 4'hF, 1'b0);
            w_send(32'hCAFE0002, 4'hF, 1'b1);
            b_expect(12'hA, 2'b00);
         end
         rd_check("concurrent", 32'h40, 8'd3, 2'b01, 12'hB, {32'd1, 32'd2, 32'd3, 32'd4}, 0);
      join
      rd_check("concurrent_wr", 32'h80, 8'd1, 2'b01, 12'hB, {32'hCAFE0001, 32'hCAFE0002}, 0);

      // Reset in the middle of a read burst
      ar_send(32'h40, 8'd3, 2'b01, 12'hC);
      r_expect("pre_reset", 32'd1, 1'b0, 12'hC, 0);
      chk("pre_reset_r_valid", rrsp.r_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("reset_r_valid", rrsp.r_valid, 0);
      chk("reset_ar_ready", rrsp.ar_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_ar_ready", rrsp.ar_ready, 1);
      chk("post_reset_r_valid", rrsp.r_valid, 0);
      rd_check("post_reset", 32'h10, 8'd0, 2'b01, 12'hD, {32'hDEADBEEF}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
